// File: rtl/g9_pkg.sv
// Shared constants and types for the G9 data-memory responder.
package g9_pkg;

    localparam int G9_ADDR_W = 10;
    localparam int G9_DATA_W = 32;
    localparam int G9_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } g9_state_e;

    // Request as seen by core-side code built at the default widths.
    typedef struct packed {
        logic                 we;
        logic [G9_ADDR_W-1:0] addr;
        logic [G9_DATA_W-1:0] wdata;
    } g9_req_t;

endpackage

// File: rtl/g9_wait_counter.sv
// Loadable down-counter with a zero flag; sizes the WAIT phase of the responder.
module g9_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/g9_data_mem_responder.sv
// G9 data-memory responder: one outstanding request, WAIT_STATES of latency, internal RAM.
// Optional macro G9_MEM_ALIGN_CHECK_EN adds rsp_err and suppresses misaligned accesses.
module g9_data_mem_responder
    import g9_pkg::*;
#(
    parameter int ADDR_W      = G9_ADDR_W,
    parameter int DATA_W      = G9_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef G9_MEM_ALIGN_CHECK_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [G9_CNT_W-1:0] WS_LOAD =
        G9_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    g9_state_e         state;
    req_t              req_q;
    logic              bad, bad_q;
    logic              accept, cnt_zero, rsp_pend;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

`ifdef G9_MEM_ALIGN_CHECK_EN
    assign bad = (req_addr[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign bad            = 1'b0;
    assign unused_addr_lo = ^req_addr[1:0];
`endif

    g9_wait_counter #(.W(G9_CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (WS_LOAD),
        .dec      (state == WAIT),
        .zero     (cnt_zero)
    );

    // RESP lasts one cycle and drops back to IDLE; the response pulse follows one
    // cycle later, so the next request can be accepted on the edge that raises it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            bad_q     <= 1'b0;
            rsp_pend  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rsp_pend;
            rsp_pend  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    req_q <= '{we: req_we, addr: req_addr[ADDR_W+1:2], wdata: req_wdata};
                    bad_q <= bad;
                    state <= (WAIT_STATES > 0) ? WAIT : RESP;
                end
                WAIT: if (cnt_zero) state <= RESP;
                RESP: begin
                    rsp_pend <= 1'b1;
                    if (!req_q.we)
                        rsp_rdata <= bad_q ? '0 : mem[req_q.addr];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef G9_MEM_ALIGN_CHECK_EN
    logic err_pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pend <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            err_pend <= (state == RESP) && bad_q;
            rsp_err  <= err_pend;
        end
    end
`endif

    // RAM is not reset; a store lands on the RESP edge only.
    always_ff @(posedge clk) begin
        if (state == RESP && req_q.we && !bad_q)
            mem[req_q.addr] <= req_q.wdata;
    end

endmodule

// File: tb/tb_g9_data_mem_responder.sv
// Self-checking bench for g9_data_mem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 fast instance).
module tb_g9_data_mem_responder;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we, rsp_valid, busy;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata, rsp_rdata;
    logic          f_req_valid, f_req_ready, f_req_we, f_rsp_valid, f_busy;
    logic [AW+1:0] f_req_addr;
    logic [DW-1:0] f_req_wdata, f_rsp_rdata;
`ifdef G9_MEM_ALIGN_CHECK_EN
    logic rsp_err, f_rsp_err;
`endif

    g9_data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef G9_MEM_ALIGN_CHECK_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    g9_data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_fast (
        .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_we(f_req_we), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
`ifdef G9_MEM_ALIGN_CHECK_EN
        .rsp_err(f_rsp_err),
`endif
        .busy(f_busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_rsp_n = 0;
    int f_rsp_cyc[$];
    logic [DW-1:0] f_rsp_dat[$];
    logic [DW-1:0] model [int];    // word index -> stored data
    logic [DW-1:0] last_rd;        // what rsp_rdata must still show on a store response

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rsp_valid) m_rsp_n++;
        if (f_rsp_valid) begin
            f_rsp_cyc.push_back(cyc);
            f_rsp_dat.push_back(f_rsp_rdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary follows");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // One request on the main instance; lat = edges from accept to the response (-1 on timeout).
    task automatic do_req(input logic we, input logic [AW+1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int lat, output logic err);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd = '0; err = 1'b0;
        while (lat < 50) begin
            @(posedge clk); lat++; #1;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
`ifdef G9_MEM_ALIGN_CHECK_EN
        err = rsp_err;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        f_req_valid = 0; f_req_we = 0; f_req_addr = '0; f_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk += 4;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk) rst = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_store_load();
        logic [DW-1:0] rd; int lat; logic err;
        do_req(1'b1, 12'h010, 32'hDEADBEEF, rd, lat, err);
        model[4] = 32'hDEADBEEF;
        n_chk += 3;
        if (lat != WS + 2) begin n_fail++; $display("FAIL store_latency got %0d want %0d", lat, WS + 2); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL store_err got %b want 0", err); end
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width rsp_valid got %b want 0", rsp_valid); end
        do_req(1'b0, 12'h010, 32'h0, rd, lat, err);
        last_rd = 32'hDEADBEEF;
        n_chk += 2;
        if (lat != WS + 2) begin n_fail++; $display("FAIL load_latency got %0d want %0d", lat, WS + 2); end
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acc[6];
        logic [DW-1:0] exp_d[6];
        logic [AW+1:0] a;
        logic [DW-1:0] d, prev;
        int t, n;
        f_rsp_cyc.delete(); f_rsp_dat.delete();
        prev = '0;
        a = '0; d = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                a = 12'($urandom_range(0, 1023) << 2);
                d = $urandom;
                exp_d[k] = prev;
            end else begin
                exp_d[k] = d;
                prev = d;
            end
            f_req_valid = 1'b1; f_req_we = (k % 2 == 0); f_req_addr = a;
            f_req_wdata = (k % 2 == 0) ? d : $urandom;
            t = 0;
            while (!f_req_ready && t < 20) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        @(negedge clk) f_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        for (int k = 1; k < 6; k++) begin
            n_chk++;
            if (acc[k] - acc[k-1] != 2) begin
                n_fail++; $display("FAIL b2b_spacing[%0d] got %0d want 2", k, acc[k] - acc[k-1]);
            end
        end
        n_chk++;
        if (f_rsp_cyc.size() != 6) begin n_fail++; $display("FAIL b2b_rsp_count got %0d want 6", f_rsp_cyc.size()); end
        n = (f_rsp_cyc.size() < 6) ? f_rsp_cyc.size() : 6;
        for (int k = 0; k < n; k++) begin
            n_chk += 2;
            if (f_rsp_cyc[k] != acc[k] + 2) begin
                n_fail++; $display("FAIL b2b_rsp_cycle[%0d] got %0d want %0d", k, f_rsp_cyc[k], acc[k] + 2);
            end
            if (f_rsp_dat[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL b2b_rsp_data[%0d] got %h want %h", k, f_rsp_dat[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [AW+1:0] a0;
        logic [DW-1:0] d0;
        int t, acc0, acc1, n0, lat;
        a0 = 12'h3A8; d0 = $urandom;
        n0 = m_rsp_n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a0; req_wdata = d0;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1 acc0 = cyc;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 20) begin
            req_we = 1'($urandom_range(0, 1));
            req_addr = 12'($urandom_range(0, 4095));
            req_wdata = $urandom;
            @(negedge clk); t++;
        end
        req_we = 1'b0; req_addr = a0; req_wdata = '0;
        @(posedge clk); #1 acc1 = cyc;
        req_valid = 1'b0;
        model[int'(a0 >> 2)] = d0;
        n_chk += 2;
        if (acc1 - acc0 != WS + 2) begin n_fail++; $display("FAIL hold_accept_spacing got %0d want %0d", acc1 - acc0, WS + 2); end
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_taken_on_rsp rsp_valid got %b want 1", rsp_valid); end
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); lat++; #1;
            if (rsp_valid) break;
        end
        n_chk += 2;
        if (lat != WS + 2) begin n_fail++; $display("FAIL hold_load_latency got %0d want %0d", lat, WS + 2); end
        if (rsp_rdata !== d0) begin n_fail++; $display("FAIL hold_load_data got %h want %h", rsp_rdata, d0); end
        last_rd = d0;
        repeat (4) @(posedge clk);
        #2;
        n_chk++;
        if (m_rsp_n - n0 != 2) begin n_fail++; $display("FAIL hold_rsp_count got %0d want 2", m_rsp_n - n0); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] rd; int lat; logic err;
        do_req(1'b1, 12'hFFC, 32'h11111111, rd, lat, err);
        do_req(1'b1, 12'h000, 32'h22222222, rd, lat, err);
        model[1023] = 32'h11111111; model[0] = 32'h22222222;
        do_req(1'b0, 12'hFFC, 32'h0, rd, lat, err);
        n_chk += 2;
        if (rd !== 32'h11111111) begin n_fail++; $display("FAIL wrap_top_word got %h want 11111111", rd); end
        if (lat != WS + 2) begin n_fail++; $display("FAIL wrap_latency got %0d want %0d", lat, WS + 2); end
        do_req(1'b0, 12'h000, 32'h0, rd, lat, err);
        n_chk++;
        if (rd !== 32'h22222222) begin n_fail++; $display("FAIL wrap_word0 got %h want 22222222", rd); end
        last_rd = 32'h22222222;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd; int lat, t, n0; logic err;
        do_req(1'b1, 12'h020, 32'h0BADF00D, rd, lat, err);
        model[8] = 32'h0BADF00D;
        n0 = m_rsp_n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'hAAAA5555;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        n_chk += 4;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", req_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== '0) begin n_fail++; $display("FAIL midrst_rdata got %h want 0", rsp_rdata); end
        @(negedge clk) rst = 1'b0;
        last_rd = '0;
        repeat (6) @(posedge clk);
        #2;
        n_chk++;
        if (m_rsp_n != n0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d responses want 0", m_rsp_n - n0); end
        do_req(1'b0, 12'h020, 32'h0, rd, lat, err);
        n_chk++;
        if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL midrst_store_dropped got %h want 0badf00d", rd); end
        last_rd = 32'h0BADF00D;
    endtask

    task automatic test_random();
        int pool[6];
        int idx, lat;
        logic we, err;
        logic [DW-1:0] rd, wd, exp;
        logic [AW+1:0] a;
        pool[0] = 0; pool[1] = 1023; pool[2] = 1;
        for (int i = 3; i < 6; i++) pool[i] = $urandom_range(2, 1022);
        for (int n = 0; n < 30; n++) begin
            idx = pool[$urandom_range(0, 5)];
            we = 1'($urandom_range(0, 1));
            if (!model.exists(idx)) we = 1'b1;
            wd = $urandom;
`ifdef G9_MEM_ALIGN_CHECK_EN
            a = 12'(idx * 4);
`else
            a = 12'(idx * 4 + $urandom_range(0, 3));
`endif
            do_req(we, a, wd, rd, lat, err);
            if (we) begin
                exp = last_rd;
                model[idx] = wd;
            end else begin
                exp = model[idx];
                last_rd = exp;
            end
            n_chk += 2;
            if (lat != WS + 2) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d want %0d", n, lat, WS + 2); end
            if (rd !== exp) begin
                n_fail++; $display("FAIL rand_rdata[%0d] we=%b addr=%h got %h want %h", n, we, a, rd, exp);
            end
        end
    endtask

`ifdef G9_MEM_ALIGN_CHECK_EN
    task automatic test_align();
        logic [DW-1:0] rd; int lat; logic err;
        do_req(1'b1, 12'h022, 32'h12345678, rd, lat, err);
        n_chk += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL align_store_err got %b want 1", err); end
        if (lat != WS + 2) begin n_fail++; $display("FAIL align_latency got %0d want %0d", lat, WS + 2); end
        do_req(1'b0, 12'h020, 32'h0, rd, lat, err);
        n_chk += 2;
        if (err !== 1'b0) begin n_fail++; $display("FAIL align_ok_err got %b want 0", err); end
        if (rd !== model[8]) begin n_fail++; $display("FAIL align_ram_unchanged got %h want %h", rd, model[8]); end
        do_req(1'b0, 12'h021, 32'h0, rd, lat, err);
        n_chk += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL align_load_err got %b want 1", err); end
        if (rd !== '0) begin n_fail++; $display("FAIL align_load_zero got %h want 0", rd); end
        last_rd = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_busy_hold();
        test_wrap();
        test_reset_mid();
`ifdef G9_MEM_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/g9_data_mem_responder.md
Name: g9_data_mem_responder

Overview:
- Responder side of the G9 processor data-memory bus: accepts load/store requests from the core, holds them for a configurable number of wait states, then completes them.
- Stores go into an internal word-addressed RAM; loads return read data with a response pulse.
- Sits between the G9 core's load/store unit and the data memory. Lets the core be exercised against non-zero memory latency.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- WAIT_STATES, 2, idle cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W+2  byte address; bits [1:0] are ignored for indexing.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data; valid only with rsp_valid.
- busy  out  1  a request is in flight.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Request handshake: a request is accepted on a rising edge when req_valid && req_ready. Only one request may be outstanding.
- On accept, req_we, word address and wdata are latched.
- FSM states:
  - IDLE: req_ready=1, busy=0. On accept, go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: req_ready=0, busy=1. Counter loads WAIT_STATES-1 on accept and decrements each cycle. At 0, go to RESP.
  - RESP: req_ready=0, busy=1. Store: RAM written this cycle. Load: RAM read into rsp_rdata. Next cycle: rsp_valid=1 for exactly one cycle, return to IDLE.
- Latency: response pulse arrives WAIT_STATES+2 cycles after the accept edge. This is 2 cycles when WAIT_STATES=0.
- Throughput:
  - The next request can be accepted on the cycle rsp_valid is high, since req_ready is 1 in IDLE.
  - Back-to-back accept spacing is WAIT_STATES+2 cycles.
- Stores also pulse rsp_valid; rsp_rdata holds its previous value on a store response.
- Load-after-store to the same address returns the new data.
- Address wrap: the word index is req_addr[ADDR_W+1:2]; higher bits do not exist, and the top word is followed by word 0 modulo depth.
- req_valid while busy: ignored, and must be held by the core. No request is lost or duplicated.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight request is dropped with no rsp_valid.
  - A store dropped before RESP is not written.
  - A store that reached the RESP write edge is written.
- rsp_valid and rsp_rdata are registered outputs; they have no combinational path from the inputs.

Optional Feature:
- Macro: G9_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - A request with req_addr[1:0]!=0 is accepted normally and goes through the same WAIT timing.
  - At RESP the store is suppressed (RAM unchanged), the load returns 0, and rsp_err=1 together with rsp_valid.
- Undefined:
  - No rsp_err port.
  - req_addr[1:0] is silently ignored.

Decomposition:
- Package g9_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the FSM state enum (IDLE, WAIT, RESP; 2-bit encoding);
  - the request struct typedef (we, addr, wdata).
- One sub-module, g9_wait_counter: loadable down-counter with a zero flag, clk and asynchronous rst. Instantiated once for the WAIT state.

Test Plan:
- Reset then store/load, WAIT_STATES=2:
  - Store 0xDEADBEEF to byte address 0x010; rsp_valid pulses 4 cycles after accept.
  - Load from 0x010 returns rsp_rdata=0xDEADBEEF with rsp_valid.
- WAIT_STATES=0 back-to-back:
  - Six alternating stores and loads with req_valid held high; accepts occur every 2 cycles.
  - Each load returns the preceding store value; no response is duplicated or missing.
- Request while busy:
  - Hold req_valid with changing addr during WAIT; only the first request is accepted.
  - The held request is taken on the rsp_valid cycle.
- Address wrap, ADDR_W=10:
  - Store 0x11111111 to byte address 0xFFC and 0x22222222 to 0x000.
  - Loads return the respective values; no aliasing between the top word and word 0.
- Reset mid-WAIT:
  - Assert rst one cycle after accepting a store of 0xAAAA5555 to 0x020.
  - No rsp_valid; a later load of 0x020 returns the prior contents; req_ready=1 immediately in reset.
- With G9_MEM_ALIGN_CHECK_EN:
  - Store to 0x022 gives rsp_err=1 with rsp_valid, and the RAM is unchanged.
  - An aligned access gives rsp_err=0.
